instr_encoder: RTL

//  Inverse of the instruction decoder: accepts symbolic RV32I instructions (op, rd, rs1, rs2, imm),

---
 rtl/instr_encoder_pkg.sv | 69 ++++++
 rtl/instr_encoder_fifo.sv | 57 +++++
 rtl/instr_encoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Holds the symbolic op set, the base-ISA opcode/funct constants used by the
// matching decoder, the loader FSM state type and a signed range helper.
package instr_encoder_pkg;

    // Symbolic operations accepted on in_op; codes 17..31 are undefined.
    typedef enum logic [4:0] {
        OP_LUI  = 5'd0,
        OP_ADDI = 5'd1,
        OP_SLLI = 5'd2,
        OP_SRLI = 5'd3,
        OP_ADD  = 5'd4,
        OP_SUB  = 5'd5,
        OP_XOR  = 5'd6,
        OP_OR   = 5'd7,
        OP_AND  = 5'd8,
        OP_LW   = 5'd9,
        OP_SW   = 5'd10,
        OP_JAL  = 5'd11,
        OP_JALR = 5'd12,
        OP_BEQ  = 5'd13,
        OP_BNE  = 5'd14,
        OP_BLT  = 5'd15,
        OP_BGE  = 5'd16
    } op_e;

    // Major opcodes
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;
    localparam logic [2:0] FUNCT3_LW      = 3'b010;
    localparam logic [2:0] FUNCT3_SW      = 3'b010;
    localparam logic [2:0] FUNCT3_JALR    = 3'b000;
    localparam logic [2:0] FUNCT3_BEQ     = 3'b000;
    localparam logic [2:0] FUNCT3_BNE     = 3'b001;
    localparam logic [2:0] FUNCT3_BLT     = 3'b100;
    localparam logic [2:0] FUNCT3_BGE     = 3'b101;

    // funct7 values
    localparam logic [6:0] FUNCT7_BASE    = 7'b0000000;
    localparam logic [6:0] FUNCT7_SUB_SRA = 7'b0100000;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True when v, read as a signed 32-bit value, lies in [lo, hi].
    function automatic logic in_srange(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// enc_fifo: synchronous FIFO buffering encoded {instr, addr} words.
// Ports:
//   clk, rst     clock and synchronous active-high reset (flushes all entries)
//   push/push_data  write request and data; ignored while full
//   pop          read request; ignored while empty
//   pop_data     current head entry
//   full/empty   occupancy flags
module enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[PTR_W-1:0]] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic RV32I instructions into 32-bit encodings and
// streams them, each tagged with a word address, toward instruction memory.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start/base_addr begin a program in IDLE at base_addr (low two bits dropped)
//   in_valid/in_ready, in_op/in_rd/in_rs1/in_rs2/in_imm/in_last  symbolic input
//   out_valid/out_ready, out_instr/out_addr                    encoded output
//   err             sticky illegal-input flag, cleared by start or rst
//   done            one-cycle pulse once the final word has been consumed
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic              done
);

    state_e              state;
    state_e              state_nx;
    logic [ADDR_W-1:0]   pc;
    logic [31:0]         word;
    logic                legal;
    logic                accept;
    logic                fifo_full;
    logic                fifo_empty;
    logic [31+ADDR_W:0]  fifo_head;
    op_e                 op;

    assign op       = op_e'(in_op);
    assign in_ready = (state == ST_RUN) && !fifo_full;
    assign accept   = in_valid && in_ready;

    // Encode mux and legality check
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (op)
            OP_LUI: begin
                legal = (in_imm[11:0] == 12'd0);
                word  = {in_imm[31:12], in_rd, OPCODE_LUI};
            end
            OP_ADDI: begin
                legal = in_srange(in_imm, -2048, 2047);
                word  = {in_imm[11:0], in_rs1, FUNCT3_ADD_SUB, in_rd, OPCODE_OP_IMM};
            end
            OP_SLLI: begin
                legal = (in_imm[31:5] == 27'd0);
                word  = {FUNCT7_BASE, in_imm[4:0], in_rs1, FUNCT3_SLL, in_rd, OPCODE_OP_IMM};
            end
            OP_SRLI: begin
                legal = (in_imm[31:5] == 27'd0);
                word  = {FUNCT7_BASE, in_imm[4:0], in_rs1, FUNCT3_SRL_SRA, in_rd, OPCODE_OP_IMM};
            end
            OP_ADD: begin
                legal = 1'b1;
                word  = {FUNCT7_BASE, in_rs2, in_rs1, FUNCT3_ADD_SUB, in_rd, OPCODE_OP};
            end
            OP_SUB: begin
                legal = 1'b1;
                word  = {FUNCT7_SUB_SRA, in_rs2, in_rs1, FUNCT3_ADD_SUB, in_rd, OPCODE_OP};
            end
            OP_XOR: begin
                legal = 1'b1;
                word  = {FUNCT7_BASE, in_rs2, in_rs1, FUNCT3_XOR, in_rd, OPCODE_OP};
            end
            OP_OR: begin
                legal = 1'b1;
                word  = {FUNCT7_BASE, in_rs2, in_rs1, FUNCT3_OR, in_rd, OPCODE_OP};
            end
            OP_AND: begin
                legal = 1'b1;
                word  = {FUNCT7_BASE, in_rs2, in_rs1, FUNCT3_AND, in_rd, OPCODE_OP};
            end
            OP_LW: begin
                legal = in_srange(in_imm, -2048, 2047);
                word  = {in_imm[11:0], in_rs1, FUNCT3_LW, in_rd, OPCODE_LOAD};
            end
            OP_SW: begin
                legal = in_srange(in_imm, -2048, 2047);
                word  = {in_imm[11:5], in_rs2, in_rs1, FUNCT3_SW, in_imm[4:0], OPCODE_STORE};
            end
            OP_JAL: begin
                legal = !in_imm[0] && in_srange(in_imm, -(1 << 20), (1 << 20) - 2);
                word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPCODE_JAL};
            end
            OP_JALR: begin
                legal = in_srange(in_imm, -2048, 2047);
                word  = {in_imm[11:0], in_rs1, FUNCT3_JALR, in_rd, OPCODE_JALR};
            end
            OP_BEQ: begin
                legal = !in_imm[0] && in_srange(in_imm, -4096, 4094);
                word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, FUNCT3_BEQ,
                         in_imm[4:1], in_imm[11], OPCODE_BRANCH};
            end
            OP_BNE: begin
                legal = !in_imm[0] && in_srange(in_imm, -4096, 4094);
                word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, FUNCT3_BNE,
                         in_imm[4:1], in_imm[11], OPCODE_BRANCH};
            end
            OP_BLT: begin
                legal = !in_imm[0] && in_srange(in_imm, -4096, 4094);
                word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, FUNCT3_BLT,
                         in_imm[4:1], in_imm[11], OPCODE_BRANCH};
            end
            OP_BGE: begin
                legal = !in_imm[0] && in_srange(in_imm, -4096, 4094);
                word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, FUNCT3_BGE,
                         in_imm[4:1], in_imm[11], OPCODE_BRANCH};
            end
            default: begin
                legal = 1'b0;
                word  = '0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state and done strobe
    always_comb begin
        state_nx = state;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                // An illegal final input still ends the program.
                if (accept && in_last) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Program counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= '0;
            err <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            pc  <= base_addr & ~ADDR_W'(3);
            err <= 1'b0;
        end else if (accept) begin
            if (legal) begin
                pc <= pc + ADDR_W'(4);
            end else begin
                err <= 1'b1;
            end
        end
    end

    enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32 + ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept && legal),
        .push_data ({word, pc}),
        .pop       (out_valid && out_ready),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_instr = fifo_head[31+ADDR_W:ADDR_W];
    assign out_addr  = fifo_head[ADDR_W-1:0];

endmodule
